shift_rotate_seq: RTL
=====================

// Module: shift_rotate_seq
// PURPOSE
//  Multi-cycle sequencer for the ALU shift/rotate path. Serves SHR, SHRA, SHL, ROR and ROL.
//  Walks a small fixed-width step stage over several cycles instead of using a full 32-way mux.
//  Sits between ALU decode and the ALU result mux.
//  Uses a valid/ready request/result handshake so control can stall on it like any multi-cycle op.
// PARAMETERS
//  DATA_W    32  operand/result width; power of two
//  MAX_STEP  4   max bit positions moved per RUN cycle; power of two, 1..DATA_W/2
// PORTS
//  clock      in   1       single clock, rising edge
//  clear_n    in   1       reset, asynchronous assert, active-low
//  req_valid  in   1       request present
//  req_ready  out  1       1 only in IDLE; accept = req_valid & req_ready
//  req_op     in   3       op code from shared package: SHR=0 SHRA=1 SHL=2 ROR=3 ROL=4
//  req_a      in   DATA_W  operand to shift/rotate
//  req_b      in   DATA_W  amount; only B % DATA_W (low log2(DATA_W) bits) is used
//  res_valid  out  1       result held and valid (DONE state)
//  res_ready  in   1       consumer takes result; pop = res_valid & res_ready
//  res_data   out  DATA_W  result; stable while res_valid
//  res_err    out  1       valid with res_data; 1 = illegal op code (res_data = req_a)
// BEHAVIOUR
//  Reset (clear_n=0, async): state IDLE, all registers cleared.
//   Output reset values: req_ready=1 once state is IDLE; res_valid=0, res_data=0, res_err=0.
//  Reset mid-RUN/DONE: operation is discarded; no result is issued.
//  States:
//   IDLE: on accept, latch op, A and amt = B % DATA_W.
//     Illegal op or amt==0 -> DONE with data=A (err=1 if illegal). Else -> RUN.
//   RUN: each cycle step = min(rem, MAX_STEP). Data <= step stage(data, op, step). rem <= rem - step.
//     Move to DONE when the new rem == 0. req_ready=0; new requests are not accepted.
//   DONE: res_valid=1. Hold data and err until pop, then -> IDLE.
//     No request is accepted in the pop cycle (req_ready is 0 in DONE).
//  Latency: res_valid rises 1 + ceil(amt/MAX_STEP) rising edges after the accept edge.
//  Op semantics per step s:
//   SHR: logical right, zero fill.  SHRA: right, fill with the bit-31 sign latched at accept.
//   SHL: left, zero fill.           ROR: {d[s-1:0], d[31:s]}.   ROL: {d[31-s:0], d[31:32-s]}.
//  Wrap rules:
//   B >= DATA_W is reduced modulo DATA_W, so B=32 or B=64 gives amt 0 and res = A.
//   Shifts never saturate; 31 is the maximum amount.
//  Simultaneous events:
//   res_valid & res_ready in DONE -> IDLE next cycle.
//   req_valid outside IDLE is ignored. The requester must hold it until accepted.
//  No combinational path from req_* to res_*. req_ready depends only on state.
// STRUCTURE
//  Shared package alu_pkg holds: op code localparams (SHR..ROL), OP_W=3,
//   state encoding (IDLE=0, RUN=1, DONE=2).
//  Sub-module shift_step (combinational): inputs d, op, s (0..MAX_STEP); output d shifted/rotated by s.
//   s=0 -> pass-through.
//  This block owns the FSM, the remaining-amount counter, the data/op/sign/err registers and the handshake.
// TESTING (MAX_STEP=4)
//  1. ROR A=0x80000001 B=1 -> res 0xC0000000, err 0, res_valid 2 edges after accept.
//  2. ROL A=0x12345678 B=35 (amt 3) -> res 0x91A2B3C0, 2 edges.
//     ROL A=0x80000000 B=1 -> 0x00000001.
//  3. SHRA A=0x80000000 B=31 -> 0xFFFFFFFF after 9 edges (8 RUN cycles).
//     SHR same operands -> 0x00000001.
//  4. SHL A=0xFFFFFFFF B=32 -> res 0xFFFFFFFF after 1 edge.
//     SHL B=4 -> 0xFFFFFFF0 after 2 edges.
//  5. Backpressure: hold res_ready=0 for 5 cycles after done.
//     -> res_valid/res_data stable, req_ready=0, second req_valid ignored.
//     Release -> IDLE, then second request served.
//  6. Illegal op=7, A=0xDEADBEEF -> res 0xDEADBEEF, err 1.
//     Separately: assert clear_n low mid-RUN -> res_valid=0 immediately, req_ready=1 after release, no stale result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift/rotate op codes and sequencer state encoding.
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_SHR  = 3'd0;
    localparam logic [OP_W-1:0] OP_SHRA = 3'd1;
    localparam logic [OP_W-1:0] OP_SHL  = 3'd2;
    localparam logic [OP_W-1:0] OP_ROR  = 3'd3;
    localparam logic [OP_W-1:0] OP_ROL  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_ROL;
    endfunction

endpackage

// File: rtl/shift_rotate_seq_step.sv
// Combinational step stage: moves data by 0..MAX_STEP bit positions.
module shift_step
    import alu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_STEP = 4,
    parameter int SW       = $clog2(MAX_STEP + 1)
) (
    input  logic [DATA_W-1:0] d_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic [SW-1:0]     s_i,
    input  logic              fill_i,
    output logic [DATA_W-1:0] d_o
);

    logic [DATA_W-1:0] ones_hi;

    // Mask of the vacated top bits, used for sign fill on SHRA
    assign ones_hi = ~({DATA_W{1'b1}} >> s_i);

    always_comb begin
        d_o = d_i;
        unique case (op_i)
            OP_SHR:  d_o = d_i >> s_i;
            OP_SHRA: d_o = (d_i >> s_i) | (fill_i ? ones_hi : '0);
            OP_SHL:  d_o = d_i << s_i;
            OP_ROR:  d_o = (d_i >> s_i) | (d_i << (DATA_W - int'(s_i)));
            OP_ROL:  d_o = (d_i << s_i) | (d_i >> (DATA_W - int'(s_i)));
            default: d_o = d_i;
        endcase
    end

endmodule

// File: rtl/shift_rotate_seq.sv
// Multi-cycle shift/rotate sequencer with valid/ready request and result ports.
module shift_rotate_seq
    import alu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_STEP = 4
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err
);

    localparam int AW = $clog2(DATA_W);
    localparam int SW = $clog2(MAX_STEP + 1);
    localparam logic [AW-1:0] MAX_A = AW'(MAX_STEP);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              sign_q, sign_d;
    logic              err_q, err_d;
    logic [AW-1:0]     rem_q, rem_d;
    logic [AW-1:0]     step_a;
    logic [AW-1:0]     rem_next;
    logic [SW-1:0]     step;
    logic [DATA_W-1:0] step_data;
    logic [AW-1:0]     amt;

    // Amount is taken modulo DATA_W, so the upper bits of B are don't-care
    logic [DATA_W-AW-1:0] unused_b;
    assign unused_b = req_b[DATA_W-1:AW];
    assign amt      = req_b[AW-1:0];

    assign step_a   = (rem_q < MAX_A) ? rem_q : MAX_A;
    assign step     = SW'(step_a);
    assign rem_next = rem_q - step_a;

    shift_step #(
        .DATA_W  (DATA_W),
        .MAX_STEP(MAX_STEP),
        .SW      (SW)
    ) u_step (
        .d_i   (data_q),
        .op_i  (op_q),
        .s_i   (step),
        .fill_i(sign_q),
        .d_o   (step_data)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        sign_d  = sign_q;
        err_d   = err_q;
        rem_d   = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    data_d = req_a;
                    sign_d = req_a[DATA_W-1];
                    rem_d  = amt;
                    err_d  = ~op_legal(req_op);
                    if (!op_legal(req_op) || amt == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                data_d = step_data;
                rem_d  = rem_next;
                if (rem_next == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            op_q    <= '0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            err_q   <= err_d;
            rem_q   <= rem_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = res_valid ? data_q : '0;
    assign res_err   = res_valid & err_q;

endmodule
